ball_renderer: RTL and testbench
================================

Name: ball_renderer

Overview:
Pixel-generation stage directly downstream of the VGA timing generator (800x600, 1056x628 total).
- Consumes column/row/active-region and the active-low hsync/vsync.
- Keeps a bouncing square ball's position, updated once per frame during vertical blank.
- Drives 4:4:4 RGB plus re-aligned sync to the VGA connector.
- Holds ball position, per-axis direction and a bounce counter.

Parameters:
- H_ACTIVE, 800, visible columns
- V_ACTIVE, 600, visible rows
- BALL_SIZE, 16, ball edge length in pixels
- STEP, 2, pixels moved per axis per frame
- BALL_COLOR, 12'hFFF, ball RGB 4:4:4
- BG_COLOR, 12'h00F, background RGB 4:4:4

Ports:
- clk  in  1  pixel clock (40 MHz)
- reset_n  in  1  asynchronous, active-high reset (asserted = 1)
- column  in  16  current column from timing generator
- row  in  16  current row from timing generator
- active  in  1  visible-region flag
- hsync_in  in  1  active-low hsync
- vsync_in  in  1  active-low vsync
- enable  in  1  1 = ball moves; 0 = position frozen
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync_out  out  1  hsync delayed to match RGB
- vsync_out  out  1  vsync delayed to match RGB
- frame_tick  out  1  one-cycle pulse at start of vertical blank
- bounce_count  out  8  wall hits, wraps 255->0

Behaviour:

Reset (async, immediate):
- ball_x = (H_ACTIVE-BALL_SIZE)/2 = 392; ball_y = (V_ACTIVE-BALL_SIZE)/2 = 292.
- dir_x = dir_y = + ; state = WAIT; bounce_count = 0; frame_tick = 0.
- RGB = 0; hsync_out = vsync_out = 1; pipeline registers cleared, with syncs cleared to 1.

Frame tick:
- frame_tick is registered high for exactly one cycle, the cycle after the sample where row == V_ACTIVE and column == 0.
- Result: one pulse per frame.

Position FSM (WAIT -> UPD_X -> UPD_Y -> WAIT, one cycle per state):
- WAIT: go to UPD_X if frame_tick and enable; otherwise stay.
- UPD_X, dir +: if ball_x + STEP >= H_ACTIVE-BALL_SIZE, then ball_x = H_ACTIVE-BALL_SIZE (784), dir_x flips to -, and it counts as a bounce. Else ball_x += STEP.
- UPD_X, dir -: if ball_x <= STEP, then ball_x = 0, dir_x flips to +, and it counts as a bounce. Else ball_x -= STEP.
- UPD_Y: same rules with V_ACTIVE and ball_y; maximum is 584.
- bounce_count increments once per axis bounce. A corner hit gives +1 in UPD_X and +1 in UPD_Y, i.e. +2 per frame.
- Arithmetic is in 16 bits and unsigned. The clamps guarantee no underflow.
- Because updates happen only in vertical blank, there is no tearing.
- enable = 0: frame_tick is still produced, but the FSM stays in WAIT.

Pixel pipeline (latency 2 clocks, fixed):
- Stage 1 registers:
  - in_ball = (column - ball_x < BALL_SIZE) && (row - ball_y < BALL_SIZE), using unsigned compares with column >= ball_x and row >= ball_y;
  - active;
  - hsync_in and vsync_in.
- Stage 2 registers:
  - RGB = BALL_COLOR if in_ball && active; BG_COLOR if active only; 0 when not active;
  - the delayed syncs.
- hsync_out and vsync_out equal hsync_in and vsync_in delayed by exactly 2 cycles.
- RGB is forced to 0 whenever the stage-1 active bit is 0.

Optional Feature:
- Macro: BALL_BORDER_EN.
- Defined: a 4-pixel frame is drawn in 12'hF00 inside the visible area (column < 4, column >= H_ACTIVE-4, row < 4, row >= V_ACTIVE-4).
  - Priority: ball > border > background.
  - The border is decoded in stage 1; latency is unchanged.
- Undefined: no border logic is present, and the border pixels show BG_COLOR.

Decomposition:
- Package ball_pkg:
  - typedef rgb444_t (packed r, g, b, 4 bits each);
  - enum state_t {WAIT, UPD_X, UPD_Y};
  - localparams H_TOTAL = 1056 and V_TOTAL = 628;
  - default colour constants.
- One sub-module: sync_delay. It is a 2-stage parameterised-width shift register with async reset to a parameterised value, used for the hsync/vsync/active alignment.

Test Plan:
1. Reset, then 1 frame with enable = 1 -> one frame_tick pulse; after UPD_Y, ball_x = 394 and ball_y = 294.
2. Run 146 frames -> ball_y = 584, dir_y = -, bounce_count = 1. Frame 147 -> ball_y = 582.
3. Run 196 frames from reset -> ball_x = 784, dir_x = -, bounce_count = 2.
4. After reset, drive column = 392, row = 292, active = 1 -> two cycles later RGB = 12'hFFF. Column = 391 -> 12'h00F. Active = 0 -> 12'h000.
5. Toggle hsync_in 1->0 at cycle N -> hsync_out goes 1->0 at cycle N+2. The same holds for vsync.
6. enable = 0 for 10 frames -> 10 frame_tick pulses, position unchanged. Assert reset_n mid-UPD_X -> state WAIT, ball_x = 392, hsync_out = 1 immediately.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types and constants for the bouncing-ball pixel stage.
// Optional feature macro: BALL_BORDER_EN (red 4-pixel frame around the visible area).
package ball_pkg;

    // Full raster size of the 800x600 timing generator feeding this stage
    localparam int unsigned H_TOTAL = 1056;
    localparam int unsigned V_TOTAL = 628;

    // Default colours, RGB 4:4:4
    localparam logic [11:0] BALL_COLOR_DEF = 12'hFFF;
    localparam logic [11:0] BG_COLOR_DEF   = 12'h00F;
    localparam logic [11:0] BORDER_COLOR   = 12'hF00;
    localparam int unsigned BORDER_W       = 4;

    // Direction encoding for dir_x / dir_y
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        UPD_X = 2'd1,
        UPD_Y = 2'd2
    } state_t;

    // Result of moving one axis by one step
    typedef struct packed {
        logic [15:0] pos;
        logic        dir;
        logic        hit;
    } axis_t;

    // Advance one axis, clamping at 0 and max_pos and flipping direction on a wall hit.
    // The clamps keep the unsigned subtraction from ever wrapping.
    function automatic axis_t step_axis(input logic [15:0] pos, input logic dir,
                                        input logic [15:0] max_pos, input logic [15:0] step);
        axis_t res;
        res.pos = pos;
        res.dir = dir;
        res.hit = 1'b0;
        if (dir == DIR_POS) begin
            if (pos + step >= max_pos) begin
                res.pos = max_pos;
                res.dir = DIR_NEG;
                res.hit = 1'b1;
            end else begin
                res.pos = pos + step;
            end
        end else begin
            if (pos <= step) begin
                res.pos = '0;
                res.dir = DIR_POS;
                res.hit = 1'b1;
            end else begin
                res.pos = pos - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Two-stage shift register with asynchronous active-high reset to a chosen value.
// Used to align the VGA syncs with the two-stage RGB pipeline.
module sync_delay #(
    parameter int unsigned            WIDTH     = 1,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // Shift din through two register stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= RESET_VAL;
            stage2_q <= RESET_VAL;
        end else begin
            stage1_q <= din;
            stage2_q <= stage1_q;
        end
    end

    assign dout = stage2_q;

endmodule

// File: rtl/ball_renderer.sv
// Pixel stage behind the 800x600 VGA timing generator: draws a bouncing square ball on a
// flat background, updating its position once per frame in vertical blank.
// Optional feature macro: BALL_BORDER_EN (red 4-pixel frame, ball has priority over it).
module ball_renderer
    import ball_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned BALL_SIZE  = 16,
    parameter int unsigned STEP       = 2,
    parameter logic [11:0] BALL_COLOR = BALL_COLOR_DEF,
    parameter logic [11:0] BG_COLOR   = BG_COLOR_DEF
) (
    input  logic        clk,
    input  logic        reset_n,      // active-high despite the name
    input  logic [15:0] column,
    input  logic [15:0] row,
    input  logic        active,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        enable,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_tick,
    output logic [7:0]  bounce_count
);

    localparam logic [15:0] X_MAX   = 16'(H_ACTIVE - BALL_SIZE);
    localparam logic [15:0] Y_MAX   = 16'(V_ACTIVE - BALL_SIZE);
    localparam logic [15:0] X_INIT  = 16'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [15:0] Y_INIT  = 16'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [15:0] STEP16  = 16'(STEP);
    localparam logic [15:0] SIZE16  = 16'(BALL_SIZE);
    localparam logic [15:0] V_BLANK = 16'(V_ACTIVE);

    // ------------------------------------------------------------------
    // Frame tick and position state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] ball_x_q, ball_x_d;
    logic [15:0] ball_y_q, ball_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic [7:0]  bounce_q, bounce_d;
    logic        frame_tick_q;
    axis_t       axis_x, axis_y;

    // One-cycle pulse when the first vertical-blank line starts
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= (row == V_BLANK) && (column == 16'd0);
        end
    end

    assign axis_x = step_axis(ball_x_q, dir_x_q, X_MAX, STEP16);
    assign axis_y = step_axis(ball_y_q, dir_y_q, Y_MAX, STEP16);

    // Position FSM: one axis per cycle after each enabled frame tick
    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        bounce_d = bounce_q;
        case (state_q)
            WAIT: begin
                if (frame_tick_q && enable) begin
                    state_d = UPD_X;
                end
            end
            UPD_X: begin
                state_d  = UPD_Y;
                ball_x_d = axis_x.pos;
                dir_x_d  = axis_x.dir;
                if (axis_x.hit) begin
                    bounce_d = bounce_q + 8'd1;
                end
            end
            UPD_Y: begin
                state_d  = WAIT;
                ball_y_d = axis_y.pos;
                dir_y_d  = axis_y.dir;
                if (axis_y.hit) begin
                    bounce_d = bounce_q + 8'd1;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // Position state registers
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q  <= WAIT;
            ball_x_q <= X_INIT;
            ball_y_q <= Y_INIT;
            dir_x_q  <= DIR_POS;
            dir_y_q  <= DIR_POS;
            bounce_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            bounce_q <= bounce_d;
        end
    end

    assign frame_tick   = frame_tick_q;
    assign bounce_count = bounce_q;

    // ------------------------------------------------------------------
    // Pixel pipeline, fixed two-cycle latency
    // ------------------------------------------------------------------
    logic [15:0] col_off, row_off;
    logic        in_ball_s;
    logic        in_ball_q;
    logic        active_q;
    rgb444_t     rgb_q, rgb_d;
    logic [1:0]  sync_dly;

    // The explicit >= guards make the wrapped unsigned offsets harmless left/above the ball
    assign col_off   = column - ball_x_q;
    assign row_off   = row - ball_y_q;
    assign in_ball_s = (column >= ball_x_q) && (col_off < SIZE16) &&
                       (row >= ball_y_q) && (row_off < SIZE16);

`ifdef BALL_BORDER_EN
    logic border_s;
    logic border_q;

    assign border_s = (column < 16'(BORDER_W)) || (column >= 16'(H_ACTIVE - BORDER_W)) ||
                      (row < 16'(BORDER_W)) || (row >= 16'(V_ACTIVE - BORDER_W));

    // Stage 1 border decode
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            border_q <= 1'b0;
        end else begin
            border_q <= border_s;
        end
    end
`endif

    // Stage 1: ball hit and visible flag
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            in_ball_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            in_ball_q <= in_ball_s;
            active_q  <= active;
        end
    end

    // Stage 2 colour select: ball over border over background, black outside visible area
    always_comb begin
        rgb_d = '0;
        if (active_q) begin
            if (in_ball_q) begin
                rgb_d = rgb444_t'(BALL_COLOR);
            end
`ifdef BALL_BORDER_EN
            else if (border_q) begin
                rgb_d = rgb444_t'(BORDER_COLOR);
            end
`endif
            else begin
                rgb_d = rgb444_t'(BG_COLOR);
            end
        end
    end

    // Stage 2 colour register
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    // Syncs idle high, so the delay line resets to ones
    sync_delay #(
        .WIDTH     (2),
        .RESET_VAL (2'b11)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (reset_n),
        .din  ({hsync_in, vsync_in}),
        .dout (sync_dly)
    );

    assign hsync_out = sync_dly[1];
    assign vsync_out = sync_dly[0];
    assign vga_r     = rgb_q.r;
    assign vga_g     = rgb_q.g;
    assign vga_b     = rgb_q.b;

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer. Frames are compressed: the bench plays the timing
// generator and only presents the row==600/column==0 sample plus a few idle cycles per frame.
module tb_ball_renderer;
    import ball_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] column, row;
    logic        active, hsync_in, vsync_in, enable;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out, frame_tick;
    logic [7:0]  bounce_count;

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt = 0;

    // Reference ball state: position, direction (+1/-1), bounce count
    int mx, my, mdx, mdy, mb;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    ball_renderer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .column       (column),
        .row          (row),
        .active       (active),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .enable       (enable),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .frame_tick   (frame_tick),
        .bounce_count (bounce_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, required summary");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mx = 392; my = 292; mdx = 1; mdy = 1; mb = 0;
    endtask

    task automatic model_axis(inout int pos, inout int dir, input int maxv);
        if (dir > 0) begin
            if (pos + 2 >= maxv) begin pos = maxv; dir = -1; mb = (mb + 1) % 256; end
            else pos = pos + 2;
        end else begin
            if (pos <= 2) begin pos = 0; dir = 1; mb = (mb + 1) % 256; end
            else pos = pos - 2;
        end
    endtask

    task automatic model_frame();
        if (enable) begin
            model_axis(mx, mdx, 784);
            model_axis(my, mdy, 584);
        end
    endtask

    task automatic apply_cycle();
        @(posedge clk);
        #1;
        if (frame_tick === 1'b1) tick_cnt++;
    endtask

    task automatic idle_inputs();
        column = 16'd1; row = 16'd0; active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic run_frame();
        row = 16'd600; column = 16'd0;
        apply_cycle();
        row = 16'd0; column = 16'd1;
        repeat (5) apply_cycle();
        model_frame();
    endtask

    task automatic test_reset();
        reset_n = 1'b1; enable = 1'b0;
        column = 16'd600; row = 16'd0; active = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_err++; $display("FAIL reset_rgb: got %h, want 000", {vga_r, vga_g, vga_b});
        end
        n_vec++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            n_err++; $display("FAIL reset_sync: got h%b v%b, want h1 v1", hsync_out, vsync_out);
        end
        n_vec++;
        if (frame_tick !== 1'b0 || bounce_count !== 8'd0) begin
            n_err++; $display("FAIL reset_tick_bounce: got %b/%0d, want 0/0", frame_tick, bounce_count);
        end
        n_vec++;
        if (dut.ball_x_q !== 16'd392 || dut.ball_y_q !== 16'd292 || dut.state_q !== WAIT) begin
            n_err++;
            $display("FAIL reset_pos: got x%0d y%0d st%0d, want x392 y292 WAIT",
                     dut.ball_x_q, dut.ball_y_q, dut.state_q);
        end
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) apply_cycle();
    endtask

    task automatic test_first_frame();
        enable = 1'b1; tick_cnt = 0;
        run_frame();
        n_vec++;
        if (tick_cnt != 1) begin
            n_err++; $display("FAIL first_frame_ticks: got %0d, want 1", tick_cnt);
        end
        n_vec++;
        if (dut.ball_x_q !== 16'd394 || dut.ball_y_q !== 16'd294) begin
            n_err++; $display("FAIL first_frame_pos: got x%0d y%0d, want x394 y294",
                              dut.ball_x_q, dut.ball_y_q);
        end
    endtask

    // Run frames up to the given total since reset, comparing against the model each frame
    task automatic run_to_frame(input int from_f, input int to_f, input string tag);
        for (int f = from_f; f <= to_f; f++) begin
            run_frame();
            n_vec++;
            if (dut.ball_x_q !== 16'(mx) || dut.ball_y_q !== 16'(my) ||
                bounce_count !== 8'(mb) || dut.state_q !== WAIT) begin
                n_err++;
                $display("FAIL %s frame %0d: got x%0d y%0d b%0d, want x%0d y%0d b%0d",
                         tag, f, dut.ball_x_q, dut.ball_y_q, bounce_count, mx, my, mb);
            end
        end
    endtask

    task automatic test_bounce_y();
        run_to_frame(2, 146, "bounce_y_walk");
        n_vec++;
        if (dut.ball_y_q !== 16'd584 || dut.dir_y_q !== DIR_NEG || bounce_count !== 8'd1) begin
            n_err++; $display("FAIL bounce_y: got y%0d d%b b%0d, want y584 d1 b1",
                              dut.ball_y_q, dut.dir_y_q, bounce_count);
        end
        run_frame();
        n_vec++;
        if (dut.ball_y_q !== 16'd582) begin
            n_err++; $display("FAIL bounce_y_after: got y%0d, want y582", dut.ball_y_q);
        end
    endtask

    task automatic test_bounce_x();
        run_to_frame(148, 196, "bounce_x_walk");
        n_vec++;
        if (dut.ball_x_q !== 16'd784 || dut.dir_x_q !== DIR_NEG || bounce_count !== 8'd2) begin
            n_err++; $display("FAIL bounce_x: got x%0d d%b b%0d, want x784 d1 b2",
                              dut.ball_x_q, dut.dir_x_q, bounce_count);
        end
    endtask

    task automatic test_enable_off();
        enable = 1'b0; tick_cnt = 0;
        repeat (10) run_frame();
        n_vec++;
        if (tick_cnt != 10) begin
            n_err++; $display("FAIL enable_off_ticks: got %0d, want 10", tick_cnt);
        end
        n_vec++;
        if (dut.ball_x_q !== 16'(mx) || dut.ball_y_q !== 16'(my) || dut.ball_x_q !== 16'd784) begin
            n_err++; $display("FAIL enable_off_pos: got x%0d y%0d, want x%0d y%0d",
                              dut.ball_x_q, dut.ball_y_q, mx, my);
        end
    endtask

    task automatic test_reset_mid_upd();
        enable = 1'b1; hsync_in = 1'b0;
        row = 16'd600; column = 16'd0;
        apply_cycle();
        row = 16'd0; column = 16'd1;
        apply_cycle();
        n_vec++;
        if (dut.state_q !== UPD_X || hsync_out !== 1'b0) begin
            n_err++; $display("FAIL pre_reset: got st%0d h%b, want UPD_X h0",
                              dut.state_q, hsync_out);
        end
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (dut.state_q !== WAIT || dut.ball_x_q !== 16'd392 || hsync_out !== 1'b1) begin
            n_err++; $display("FAIL async_reset: got st%0d x%0d h%b, want WAIT x392 h1",
                              dut.state_q, dut.ball_x_q, hsync_out);
        end
        apply_cycle();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) apply_cycle();
    endtask

    task automatic test_pixel_basic();
        logic [15:0] cols [3];
        logic        acts [3];
        logic [11:0] want [3];
        cols[0] = 16'd392; acts[0] = 1'b1; want[0] = 12'hFFF;
        cols[1] = 16'd391; acts[1] = 1'b1; want[1] = 12'h00F;
        cols[2] = 16'd392; acts[2] = 1'b0; want[2] = 12'h000;
        for (int i = 0; i < 3; i++) begin
            column = cols[i]; row = 16'd292; active = acts[i];
            apply_cycle();
            apply_cycle();
            n_vec++;
            if ({vga_r, vga_g, vga_b} !== want[i]) begin
                n_err++; $display("FAIL pixel_basic %0d: got %h, want %h",
                                  i, {vga_r, vga_g, vga_b}, want[i]);
            end
        end
        idle_inputs();
        repeat (2) apply_cycle();
    endtask

    task automatic test_sync();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            repeat (3) apply_cycle();
            if (k == 0) hsync_in = 1'b0; else vsync_in = 1'b0;
            apply_cycle();
            n_vec++;
            if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
                n_err++; $display("FAIL sync_n1 %0d: got h%b v%b, want h1 v1", k, hsync_out, vsync_out);
            end
            apply_cycle();
            n_vec++;
            if (hsync_out !== (k != 0) || vsync_out !== (k == 0)) begin
                n_err++; $display("FAIL sync_n2 %0d: got h%b v%b, want h%b v%b",
                                  k, hsync_out, vsync_out, k != 0, k == 0);
            end
        end
        idle_inputs();
        repeat (3) apply_cycle();
    endtask

    // Random pixels around a ball that moves between bursts
    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   c, r;
        logic in_b, bord;
        enable = 1'b1;
        for (int round = 0; round < 6; round++) begin
            run_to_frame(0, $urandom_range(1, 60) - 1, "b2b_frames");
            q.delete();
            for (int i = 0; i < 80; i++) begin
                apply_cycle();
                if (q.size() == 2) begin
                    e = q.pop_front();
                    n_vec++;
                    if ({vga_r, vga_g, vga_b} !== e.rgb || hsync_out !== e.hs || vsync_out !== e.vs) begin
                        n_err++;
                        $display("FAIL b2b_pixel r%0d i%0d: got %h h%b v%b, want %h h%b v%b",
                                 round, i, {vga_r, vga_g, vga_b}, hsync_out, vsync_out,
                                 e.rgb, e.hs, e.vs);
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    c = $urandom_range(0, 1055); r = $urandom_range(0, 627);
                end else begin
                    c = mx + $urandom_range(0, 39) - 20; r = my + $urandom_range(0, 39) - 20;
                    if (c < 0) c = 0;
                    if (r < 0) r = 0;
                end
                if (r == 600 && c == 0) c = 1;
                column = 16'(c); row = 16'(r);
                active = ($urandom_range(0, 3) != 0);
                hsync_in = $urandom_range(0, 1) != 0;
                vsync_in = $urandom_range(0, 1) != 0;
                in_b = (c >= mx) && (c < mx + 16) && (r >= my) && (r < my + 16);
                bord = (c < 4) || (c >= 796) || (r < 4) || (r >= 596);
                e.hs = hsync_in; e.vs = vsync_in;
                if (!active) e.rgb = 12'h000;
                else if (in_b) e.rgb = 12'hFFF;
`ifdef BALL_BORDER_EN
                else if (bord) e.rgb = 12'hF00;
`endif
                else e.rgb = 12'h00F;
                q.push_back(e);
            end
            idle_inputs();
            repeat (3) apply_cycle();
        end
    endtask

    initial begin
        idle_inputs();
        enable = 1'b0;
        model_reset();
        test_reset();
        test_first_frame();
        test_bounce_y();
        test_bounce_x();
        test_enable_off();
        test_reset_mid_upd();
        test_pixel_basic();
        test_sync();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
